// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants, state encoding and helpers for the sequential multiplier
//
// Purpose: single source for the FSM state encoding, the default operand width
//          and the counter-width helper used by sequential_multiplier.
// Ports:   none (package)
`timescale 1ns/100ps
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  // Counter must index WIDTH RUN cycles (0 .. WIDTH-1); keep at least one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(MULT_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_negate.sv
// rtl/mult_negate.sv - conditional two's-complement negate
//
// Purpose: o_value = i_negate ? -i_value : i_value (W-bit two's complement).
//          Used for operand magnitudes and for the final product sign fix-up.
// Ports:
//   i_value   in  W  value to pass through or negate
//   i_negate  in  1  1: negate, 0: pass through
//   o_value   out W  result
`timescale 1ns/100ps
module mult_negate #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_value,
  input  logic         i_negate,
  output logic [W-1:0] o_value
);

  logic [W-1:0] w_negated;

  assign w_negated = ~i_value + W'(1);
  assign o_value   = i_negate ? w_negated : i_value;

endmodule

// File: rtl/sequential_multiplier.sv
// rtl/sequential_multiplier.sv - iterative shift-add multiplier, one multiplier bit per clock
//
// Purpose: WIDTH x WIDTH -> 2*WIDTH multiply (signed or unsigned) for MULT/MULTU.
//          Operands are reduced to magnitudes on the accepting edge, WIDTH shift-add
//          steps run on magnitudes, and the sign is reapplied on the final edge.
// Ports:
//   clock      in  1      rising-edge clock
//   reset      in  1      asynchronous active-high reset
//   start      in  1      begin an operation (accepted in IDLE or DONE only)
//   is_signed  in  1      1: two's-complement operands, 0: unsigned
//   a          in  WIDTH  multiplicand
//   b          in  WIDTH  multiplier
//   hi         out WIDTH  upper half of product
//   lo         out WIDTH  lower half of product
//   busy       out 1      operation in progress
//   done       out 1      one-cycle pulse, hi/lo just updated
`timescale 1ns/100ps
module sequential_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_BITS = cnt_width(WIDTH);

  state_t                r_state;
  logic [CNT_BITS-1:0]   r_count;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic [2*WIDTH-1:0]    r_acc;
  logic                  r_neg;
  logic [WIDTH-1:0]      r_hi;
  logic [WIDTH-1:0]      r_lo;

  logic [WIDTH-1:0]      w_a_mag;
  logic [WIDTH-1:0]      w_b_mag;
  logic [WIDTH-1:0]      w_addend;
  logic [WIDTH:0]        w_sum;
  logic [2*WIDTH-1:0]    w_acc_next;
  logic [2*WIDTH-1:0]    w_product;

  // Magnitude of the most negative value wraps back to itself, which is the
  // correct unsigned magnitude (e.g. 0x80000000 -> 2^31).
  mult_negate #(.W(WIDTH)) u_neg_a (
    .i_value  (a),
    .i_negate (is_signed & a[WIDTH-1]),
    .o_value  (w_a_mag)
  );

  mult_negate #(.W(WIDTH)) u_neg_b (
    .i_value  (b),
    .i_negate (is_signed & b[WIDTH-1]),
    .o_value  (w_b_mag)
  );

  // Add into the upper half with the carry kept, then shift the whole
  // accumulator right so the carry lands in the top bit.
  assign w_addend   = r_b[0] ? r_a : '0;
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

  mult_negate #(.W(2*WIDTH)) u_neg_p (
    .i_value  (w_acc_next),
    .i_negate (r_neg),
    .o_value  (w_product)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_neg   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a     <= w_a_mag;
            r_b     <= w_b_mag;
            r_neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc   <= '0;
            r_count <= '0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_acc   <= w_acc_next;
          r_b     <= r_b >> 1;
          r_count <= r_count + CNT_BITS'(1);
          // Final step: publish the sign-corrected product straight from the
          // combinational next-accumulator so hi/lo update on this edge.
          if (r_count == CNT_BITS'(WIDTH - 1)) begin
            {r_hi, r_lo} <= w_product;
            r_state      <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_sequential_multiplier.sv
// tb/tb_sequential_multiplier.sv - self-checking bench for sequential_multiplier
`timescale 1ns/100ps
module tb_sequential_multiplier;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [63:0] prev_product = '0;

  sequential_multiplier #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done)
  );

  always #1 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx;
    longint sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Runs one operation. inj >= 0 pulses start with a=1,b=1 after that many RUN edges.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                        input int inj, input string name);
    logic [63:0] exp;
    int cyc;
    int bcnt;
    logic got_done;
    exp = model(ta, tb_v, ts);
    @(negedge clock);
    start = 1'b1; a = ta; b = tb_v; is_signed = ts;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom);
    bcnt = busy ? 1 : 0;
    cyc = 0;
    got_done = 1'b0;
    while (cyc < 100 && !got_done) begin
      if (cyc == inj) begin
        start = 1'b1; a = 32'd1; b = 32'd1; is_signed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (done) got_done = 1'b1;
      else if (busy) bcnt++;
      if (cyc == 16) begin
        total++;
        if ({hi, lo} !== prev_product) begin
          bad++;
          $display("FAIL %s hold_in_run got=%h want=%h", name, {hi, lo}, prev_product);
        end
      end
    end
    start = 1'b0;
    total++;
    if (!got_done || cyc != 32) begin
      bad++;
      $display("FAIL %s latency got=%0d done=%0b want=32", name, cyc, got_done);
    end
    total++;
    if (bcnt != 32) begin
      bad++;
      $display("FAIL %s busy_cycles got=%0d want=32", name, bcnt);
    end
    total++;
    if ({hi, lo} !== exp) begin
      bad++;
      $display("FAIL %s product got=%h want=%h", name, {hi, lo}, exp);
    end
    prev_product = exp;
    repeat (10) @(negedge clock);
    total++;
    if ({hi, lo} !== exp || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s hold_after got=%h busy=%b done=%b want=%h busy=0 done=0",
               name, {hi, lo}, busy, done, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done);
    end
    reset = 1'b0;
    prev_product = '0;
  endtask

  task automatic test_multu_basic();
    run_op(32'd20, 32'd10, 1'b0, -1, "multu_20x10");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, "multu_max");
  endtask

  task automatic test_mult_signed();
    run_op(32'hFFFF_FFFD, 32'd7, 1'b1, -1, "mult_m3x7");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, -1, "mult_minxmin");
    run_op(32'd0, 32'hFFFF_FFFB, 1'b1, -1, "mult_0xm5");
    run_op(32'h8000_0000, 32'd1, 1'b1, -1, "mult_minx1");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1, "mult_m1xm1");
  endtask

  task automatic test_start_ignored();
    run_op(32'd20, 32'd10, 1'b0, 10, "start_in_run");
  endtask

  task automatic test_async_reset();
    int cyc;
    @(negedge clock);
    start = 1'b1; a = 32'd20; b = 32'd10; is_signed = 1'b0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    for (cyc = 1; cyc < 15; cyc++) @(negedge clock);
    #0.5;
    reset = 1'b1;
    #0.1;
    total++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    prev_product = '0;
    run_op(32'd6, 32'd7, 1'b0, -1, "after_reset_6x7");
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic got_done;
    @(negedge clock);
    start = 1'b1; a = 32'd20; b = 32'd10; is_signed = 1'b0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    got_done = 1'b0;
    while (cyc < 100 && !got_done) begin
      @(posedge clock); cyc++; @(negedge clock);
      got_done = done;
    end
    total++;
    if (!got_done || {hi, lo} !== 64'd200) begin
      bad++;
      $display("FAIL b2b_first got=%h done=%b want=%h", {hi, lo}, got_done, 64'd200);
    end
    start = 1'b1; a = 32'd3; b = 32'd5; is_signed = 1'b0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    cyc = 0;
    got_done = 1'b0;
    while (cyc < 100 && !got_done) begin
      @(posedge clock); cyc++; @(negedge clock);
      got_done = done;
    end
    total++;
    if (!got_done || cyc != 32 || {hi, lo} !== 64'd15) begin
      bad++;
      $display("FAIL b2b_second got=%h cycles=%0d want=%h cycles=32", {hi, lo}, cyc, 64'd15);
    end
    prev_product = 64'd15;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [31:0] rb;
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'd0;
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom), -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_multu_basic();
    test_mult_signed();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
